iob_native_ram_responder: RTL

//  Responder (slave) end of the IOb native bus driven by the CPU wrapper's ibus/dbus.

---
 rtl/iob_native_ram_responder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/iob_native_ram_responder.sv
// IOb native bus responder backed by an internal word RAM with programmable wait states.
// Optional macro RESP_RANGE_CHECK_EN flags accesses above the RAM window with err.
`ifndef REQ_W
`define REQ_W (1+ADDR_W+DATA_W+DATA_W/8)
`endif
`ifndef RESP_W
`define RESP_W (DATA_W+1)
`endif

module iob_native_ram_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_ADDR_W  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [`REQ_W-1:0]  req,
    output logic [`RESP_W-1:0] resp,
    output logic               err
);
    localparam int STRB_W = DATA_W / 8;
    localparam int DEPTH  = 1 << MEM_ADDR_W;
    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACC,
        ST_RESP
    } state_t;

    state_t state, next_state;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [DATA_W-1:0] rdata_q;
    logic [3:0]        cnt;

    logic                  capture;
    logic                  is_write;
    logic                  out_of_range;
    logic                  ready;
    logic [MEM_ADDR_W-1:0] word_idx;

    assign req_valid = req[`REQ_W-1];
    assign req_addr  = req[ADDR_W+DATA_W+STRB_W-1 -: ADDR_W];
    assign req_wdata = req[DATA_W+STRB_W-1 -: DATA_W];
    assign req_wstrb = req[STRB_W-1:0];

    assign word_idx = addr_q[MEM_ADDR_W+1:2];
    assign is_write = |wstrb_q;
    assign ready    = (state == ST_RESP);
    assign resp     = {rdata_q, ready};

    // A new request may be taken both from IDLE and in the ready cycle itself.
    assign capture = req_valid && ((state == ST_IDLE) || (state == ST_RESP));

`ifdef RESP_RANGE_CHECK_EN
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr_q[1:0];
    assign out_of_range    = |addr_q[ADDR_W-1:MEM_ADDR_W+2];
    assign err             = ready && out_of_range;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_q[ADDR_W-1:MEM_ADDR_W+2], addr_q[1:0]};
    assign out_of_range     = 1'b0;
    assign err              = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_RESP: begin
                if (req_valid)
                    next_state = (WAIT_STATES > 0) ? ST_WAIT : ST_ACC;
                else
                    next_state = ST_IDLE;
            end
            ST_WAIT: begin
                if (cnt == 4'd1)
                    next_state = ST_ACC;
            end
            ST_ACC:  next_state = ST_RESP;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= next_state;
            if (capture) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                cnt     <= WS_INIT;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (state == ST_ACC) begin
                if (is_write || out_of_range)
                    rdata_q <= '0;
                else
                    rdata_q <= mem[word_idx];
            end
        end
    end

    // RAM has no reset; a reset landing on the ACC cycle still suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && (state == ST_ACC) && is_write && !out_of_range) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (wstrb_q[i])
                    mem[word_idx][i*8 +: 8] <= wdata_q[i*8 +: 8];
            end
        end
    end
endmodule
